// File: rtl/pc_pkg.sv
// Shared constants and the next-PC select encoding for the fetch-stage PC generator.
package pc_pkg;
   localparam int          XLEN_DEF         = 32;
   localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;

   typedef enum logic [2:0] {
      PC_HOLD,
      PC_REDIRECT,
      PC_RAS,
      PC_PRED,
      PC_SEQ
   } pc_sel_e;
endpackage

// File: rtl/pc_fetch_unit_ras.sv
// Return address stack: circular buffer with a top pointer and a saturating count.
// A push on a full stack overwrites the oldest entry; push+pop together replaces the top.
module ras_stack
   import pc_pkg::*;
#(
   parameter int XLEN      = XLEN_DEF,
   parameter int RAS_DEPTH = 8
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             push,
   input  logic                             pop,
   input  logic                             flush,
   input  logic [XLEN-1:0]                  push_data,
   output logic [XLEN-1:0]                  top,
   output logic [$clog2(RAS_DEPTH+1)-1:0]   count
);
   localparam int PW = $clog2(RAS_DEPTH);
   localparam int CW = $clog2(RAS_DEPTH+1);

   logic [XLEN-1:0] mem [RAS_DEPTH];
   logic [PW-1:0]   top_ptr;
   logic [PW-1:0]   top_ptr_inc;
   logic [PW-1:0]   wr_ptr;
   logic            do_pop;

   assign do_pop      = pop && (count != '0);
   assign top_ptr_inc = top_ptr + 1'b1;
   assign wr_ptr      = do_pop ? top_ptr : top_ptr_inc;
   assign top         = mem[top_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         top_ptr <= '0;
         count   <= '0;
      end else if (flush) begin
         count <= '0;
      end else if (push && !do_pop) begin
         top_ptr <= top_ptr_inc;
         if (count != CW'(RAS_DEPTH))
            count <= count + 1'b1;
      end else if (do_pop && !push) begin
         top_ptr <= top_ptr - 1'b1;
         count   <= count - 1'b1;
      end
   end

   // Storage carries no reset: entries above count are never observed.
   always_ff @(posedge clk) begin
      if (push && !flush)
         mem[wr_ptr] <= push_data;
   end
endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch-stage PC generator: redirect > stall > RAS return > predicted jump > sequential.
// Non-sequential targets are word-aligned before loading and flagged if they were not.
module pc_fetch_unit
   import pc_pkg::*;
#(
   parameter int              XLEN         = XLEN_DEF,
   parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(RESET_VECTOR_DEF),
   parameter int              RAS_DEPTH    = 8,
   parameter int              INC          = 4
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             stall_i,
   input  logic                             redirect_i,
   input  logic [XLEN-1:0]                  redirect_target_i,
   input  logic                             ras_flush_i,
   input  logic                             pred_taken_i,
   input  logic [XLEN-1:0]                  pred_target_i,
   input  logic                             call_i,
   input  logic                             ret_i,
   output logic [XLEN-1:0]                  pc_o,
   output logic [XLEN-1:0]                  pc_plus_inc_o,
   output logic [$clog2(RAS_DEPTH+1)-1:0]   ras_count_o,
   output logic                             ras_underflow_o,
   output logic                             misaligned_o
);
   pc_sel_e         sel;
   logic [XLEN-1:0] raw_target;
   logic [XLEN-1:0] pc_next;
   logic [XLEN-1:0] ras_top;
   logic            ras_empty;
   logic            accept;
   logic            underflow_next;
   logic            misaligned_next;

   assign pc_plus_inc_o = pc_o + XLEN'(INC);
   assign ras_empty     = (ras_count_o == '0);
   assign accept        = !redirect_i && !stall_i;

   always_comb begin
      sel        = PC_SEQ;
      raw_target = pc_plus_inc_o;
      if (redirect_i) begin
         sel        = PC_REDIRECT;
         raw_target = redirect_target_i;
      end else if (stall_i) begin
         sel        = PC_HOLD;
         raw_target = pc_o;
      end else if (ret_i && !ras_empty) begin
         sel        = PC_RAS;
         raw_target = ras_top;
      end else if (pred_taken_i) begin
         sel        = PC_PRED;
         raw_target = pred_target_i;
      end
   end

   always_comb begin
      pc_next         = raw_target;
      misaligned_next = 1'b0;
      if (sel == PC_REDIRECT || sel == PC_RAS || sel == PC_PRED) begin
         pc_next         = {raw_target[XLEN-1:2], 2'b00};
         misaligned_next = (raw_target[1:0] != 2'b00);
      end
   end

   // A return on an empty stack still falls through to the prediction / sequential path.
   assign underflow_next = accept && ret_i && ras_empty;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_o            <= RESET_VECTOR;
         ras_underflow_o <= 1'b0;
         misaligned_o    <= 1'b0;
      end else begin
         pc_o            <= pc_next;
         ras_underflow_o <= underflow_next;
         misaligned_o    <= misaligned_next;
      end
   end

   ras_stack #(
      .XLEN      (XLEN),
      .RAS_DEPTH (RAS_DEPTH)
   ) u_ras (
      .clk       (clk),
      .rst       (rst),
      .push      (accept && call_i),
      .pop       (accept && ret_i),
      .flush     (redirect_i && ras_flush_i),
      .push_data (pc_plus_inc_o),
      .top       (ras_top),
      .count     (ras_count_o)
   );
endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scenario and randomized checks of pc_fetch_unit against a queue-based reference model.
module tb_pc_fetch_unit;
   localparam int          DEPTH = 4;
   localparam logic [31:0] RV    = 32'h0000_0100;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stall = 1'b0, redirect = 1'b0, flush = 1'b0, pred = 1'b0, call = 1'b0, ret = 1'b0;
   logic [31:0] rtarget = '0, ptarget = '0;
   logic [31:0] pc, pc_inc;
   logic [2:0]  cnt;
   logic        under, mis;

   int checks   = 0;
   int failures = 0;

   // Reference model: the RAS is a queue with the newest link at the back.
   logic [31:0] m_pc;
   logic [31:0] m_ras[$];
   bit          m_under, m_mis;

   always #5 clk = ~clk;

   pc_fetch_unit #(
      .XLEN         (32),
      .RESET_VECTOR (RV),
      .RAS_DEPTH    (DEPTH),
      .INC          (4)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .stall_i           (stall),
      .redirect_i        (redirect),
      .redirect_target_i (rtarget),
      .ras_flush_i       (flush),
      .pred_taken_i      (pred),
      .pred_target_i     (ptarget),
      .call_i            (call),
      .ret_i             (ret),
      .pc_o              (pc),
      .pc_plus_inc_o     (pc_inc),
      .ras_count_o       (cnt),
      .ras_underflow_o   (under),
      .misaligned_o      (mis)
   );

   task automatic model_reset();
      m_pc = RV;
      m_ras.delete();
      m_under = 0;
      m_mis   = 0;
   endtask

   task automatic model_step();
      logic [31:0] tgt;
      bit          jump;
      tgt     = '0;
      jump    = 0;
      m_under = 0;
      m_mis   = 0;
      if (redirect) begin
         tgt  = rtarget;
         jump = 1;
         if (flush) m_ras.delete();
      end else if (!stall) begin
         if (ret && m_ras.size() > 0) begin
            tgt  = m_ras[$];
            jump = 1;
            if (call) m_ras[$] = m_pc + 32'd4;
            else      void'(m_ras.pop_back());
         end else begin
            if (ret) m_under = 1;
            if (pred) begin
               tgt  = ptarget;
               jump = 1;
            end
            if (call) begin
               m_ras.push_back(m_pc + 32'd4);
               if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
            end
         end
      end
      if (jump) begin
         m_mis = (tgt % 4) != 0;
         m_pc  = tgt - (tgt % 4);
      end else if (!stall) begin
         m_pc = m_pc + 32'd4;
      end
   endtask

   task automatic step(input bit rd, input logic [31:0] rt, input bit fl, input bit st,
                       input bit pr, input logic [31:0] pt, input bit c, input bit r);
      redirect = rd; rtarget = rt; flush = fl; stall = st;
      pred = pr; ptarget = pt; call = c; ret = r;
      @(posedge clk);
      model_step();
      #1;
      $display("txn rd=%0b st=%0b pr=%0b call=%0b ret=%0b pc=%h cnt=%0d uf=%0b mis=%0b",
               rd, st, pr, c, r, pc, cnt, under, mis);
      redirect = 0; flush = 0; stall = 0; pred = 0; call = 0; ret = 0;
   endtask

   task automatic test_reset();
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      checks++; if (pc !== RV) begin failures++; $display("FAIL reset_pc got=%h want=%h", pc, RV); end
      checks++; if (cnt !== 3'd0) begin failures++; $display("FAIL reset_cnt got=%0d want=0", cnt); end
      checks++; if (under !== 1'b0 || mis !== 1'b0) begin failures++; $display("FAIL reset_pulses got=%b%b want=00", under, mis); end
      @(negedge clk) rst = 0;
      step(0, 0, 0, 0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0);
      checks++; if (pc !== m_pc) begin failures++; $display("FAIL pre_reset_pc got=%h want=%h", pc, m_pc); end
      #3 rst = 1;
      #1;
      checks++; if (pc !== RV) begin failures++; $display("FAIL async_reset_pc got=%h want=%h", pc, RV); end
      checks++; if (cnt !== 3'd0) begin failures++; $display("FAIL async_reset_cnt got=%0d want=0", cnt); end
      model_reset();
      @(negedge clk) rst = 0;
      step(0, 0, 0, 0, 0, 0, 0, 0);
      checks++; if (pc !== 32'h104) begin failures++; $display("FAIL after_reset_1 got=%h want=00000104", pc); end
      step(0, 0, 0, 0, 0, 0, 0, 0);
      checks++; if (pc !== 32'h108) begin failures++; $display("FAIL after_reset_2 got=%h want=00000108", pc); end
   endtask

   task automatic test_stall_redirect();
      step(1, 32'h10, 1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         step(0, 0, 0, 1, i == 1, 32'h500, i == 0, i == 2);
         checks++; if (pc !== 32'h10) begin failures++; $display("FAIL stall_hold[%0d] got=%h want=00000010", i, pc); end
         checks++; if (cnt !== 3'd0 || under !== 1'b0) begin failures++; $display("FAIL stall_ras[%0d] got cnt=%0d uf=%b want cnt=0 uf=0", i, cnt, under); end
      end
      step(1, 32'h80, 0, 1, 0, 0, 0, 0);
      checks++; if (pc !== 32'h80) begin failures++; $display("FAIL stall_redirect got=%h want=00000080", pc); end
   endtask

   task automatic test_call_ret();
      step(1, 32'h20, 1, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 1, 32'h200, 1, 0);
      checks++; if (pc !== 32'h200 || cnt !== 3'd1) begin failures++; $display("FAIL call got pc=%h cnt=%0d want pc=00000200 cnt=1", pc, cnt); end
      step(0, 0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 1);
      checks++; if (pc !== 32'h24 || cnt !== 3'd0) begin failures++; $display("FAIL ret got pc=%h cnt=%0d want pc=00000024 cnt=0", pc, cnt); end
   endtask

   task automatic test_overflow();
      step(1, 32'h1000, 1, 0, 0, 0, 0, 0);
      for (int i = 1; i <= 5; i++)
         step(0, 0, 0, 0, 1, 32'(i + 1) << 12, 1, 0);
      checks++; if (cnt !== 3'd4) begin failures++; $display("FAIL overflow_cnt got=%0d want=4", cnt); end
      for (int i = 0; i < 4; i++) begin
         step(0, 0, 0, 0, 0, 0, 0, 1);
         checks++; if (pc !== ((32'(5 - i) << 12) + 32'h4)) begin failures++; $display("FAIL overflow_ret[%0d] got=%h want=%h", i, pc, (32'(5 - i) << 12) + 32'h4); end
      end
      step(0, 0, 0, 0, 0, 0, 0, 1);
      checks++; if (pc !== 32'h2008 || under !== 1'b1) begin failures++; $display("FAIL underflow got pc=%h uf=%b want pc=00002008 uf=1", pc, under); end
      step(0, 0, 0, 0, 0, 0, 0, 0);
      checks++; if (under !== 1'b0) begin failures++; $display("FAIL underflow_pulse got=%b want=0", under); end
   endtask

   task automatic test_call_ret_same();
      step(1, 32'h2C, 1, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 1, 32'h40, 1, 0);
      step(0, 0, 0, 0, 0, 0, 1, 1);
      checks++; if (pc !== 32'h30 || cnt !== 3'd1) begin failures++; $display("FAIL call_ret got pc=%h cnt=%0d want pc=00000030 cnt=1", pc, cnt); end
      step(0, 0, 0, 0, 0, 0, 0, 1);
      checks++; if (pc !== 32'h44 || cnt !== 3'd0) begin failures++; $display("FAIL call_ret_top got pc=%h cnt=%0d want pc=00000044 cnt=0", pc, cnt); end
   endtask

   task automatic test_align_wrap();
      step(1, 32'h83, 0, 0, 0, 0, 0, 0);
      checks++; if (pc !== 32'h80 || mis !== 1'b1) begin failures++; $display("FAIL align got pc=%h mis=%b want pc=00000080 mis=1", pc, mis); end
      step(0, 0, 0, 0, 0, 0, 0, 0);
      checks++; if (pc !== 32'h84 || mis !== 1'b0) begin failures++; $display("FAIL align_pulse got pc=%h mis=%b want pc=00000084 mis=0", pc, mis); end
      step(1, 32'hFFFF_FFFC, 0, 0, 0, 0, 0, 0);
      checks++; if (pc_inc !== 32'h0) begin failures++; $display("FAIL wrap_inc got=%h want=00000000", pc_inc); end
      step(0, 0, 0, 0, 0, 0, 1, 0);
      checks++; if (pc !== 32'h0 || cnt !== 3'd1) begin failures++; $display("FAIL wrap got pc=%h cnt=%0d want pc=00000000 cnt=1", pc, cnt); end
      step(0, 0, 1, 0, 0, 0, 0, 0);
      checks++; if (cnt !== 3'd1) begin failures++; $display("FAIL flush_no_redirect got=%0d want=1", cnt); end
      step(1, 32'h300, 1, 0, 0, 0, 0, 0);
      checks++; if (cnt !== 3'd0 || pc !== 32'h300) begin failures++; $display("FAIL flush got pc=%h cnt=%0d want pc=00000300 cnt=0", pc, cnt); end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         logic [31:0] rt;
         rt = ($urandom_range(0, 20) == 0) ? 32'hFFFF_FFFC : $urandom;
         step($urandom_range(0, 9) == 0, rt, $urandom_range(0, 1) == 0,
              $urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0, $urandom,
              $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0);
         checks++; if (pc !== m_pc) begin failures++; $display("FAIL rand_pc[%0d] got=%h want=%h", i, pc, m_pc); end
         checks++; if (pc_inc !== m_pc + 32'd4) begin failures++; $display("FAIL rand_inc[%0d] got=%h want=%h", i, pc_inc, m_pc + 32'd4); end
         checks++; if (cnt !== 3'(m_ras.size())) begin failures++; $display("FAIL rand_cnt[%0d] got=%0d want=%0d", i, cnt, m_ras.size()); end
         checks++; if (under !== m_under || mis !== m_mis) begin failures++; $display("FAIL rand_pulses[%0d] got uf=%b mis=%b want uf=%b mis=%b", i, under, mis, m_under, m_mis); end
      end
   endtask

   initial begin
      test_reset();
      test_stall_redirect();
      test_call_ret();
      test_overflow();
      test_call_ret_same();
      test_align_wrap();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
